// File: rtl/ram_port_master.sv
// ram_port_master: burst master for a single-port synchronous RAM.
// A host command starts a write or read burst of (req_len+1) beats from
// req_addr. Addresses wrap modulo the RAM depth. Read data is captured two
// cycles after its address is issued and is delivered without backpressure.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command; no RAM strobes; ram_addr holds last value
// WRITE | forwarding write beats to the RAM as wr_valid allows
// READ  | issuing one read address per cycle
// DRAIN | one extra cycle so the final read word can be captured
module ram_port_master #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    // host command channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    // write beat channel
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    // read beat channel
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    // RAM port
    output logic          ram_cs,
    output logic          ram_w_en,
    output logic          ram_r_en,
    output logic          ram_o_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    // last address actually presented with a strobe; DRAIN and IDLE show it
    logic [AW-1:0] last_q, last_d;
    // a read address was issued in the previous cycle, so RAM output is valid now
    logic          oen_q, oen_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;

    // State and counters; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            oen_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            oen_q      <= oen_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic and RAM strobes for each state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        oen_d     = 1'b0;
        done_d    = 1'b0;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_cs    = 1'b0;
        ram_w_en  = 1'b0;
        ram_r_en  = 1'b0;
        ram_addr  = last_q;
        ram_din   = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = req_write ? WRITE : READ;
                end
            end

            WRITE: begin
                wr_ready = 1'b1;
                ram_addr = addr_q;
                ram_din  = wr_data;
                ram_cs   = wr_valid;
                ram_w_en = wr_valid;
                if (wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    last_d = addr_q;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            READ: begin
                ram_cs   = 1'b1;
                ram_r_en = 1'b1;
                ram_addr = addr_q;
                addr_d   = addr_q + 1'b1;
                cnt_d    = cnt_q - 1'b1;
                last_d   = addr_q;
                oen_d    = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // re-present the last address so the port stays quiet/stable
                ram_cs   = 1'b1;
                ram_r_en = 1'b1;
                ram_addr = last_q;
                state_d  = IDLE;
                // lines up with the final rd_valid, which lands next cycle
                done_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data capture: the word is registered whenever the RAM output is enabled.
    always_comb begin
        rd_valid_d = oen_q;
        rd_data_d  = oen_q ? ram_dout : rd_data_q;
    end

    assign ram_o_en = oen_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Testbench for ram_port_master: cycle-level vector table for write, gapped
// write, wrap read and single read, then a reset-mid-burst sequence.
module tb_ram_port_master;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr, req_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, done;
    logic          ram_cs, ram_w_en, ram_r_en, ram_o_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    ram_port_master #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .ram_cs(ram_cs), .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_o_en(ram_o_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // synchronous RAM model: one-cycle read latency
    always @(posedge clk) begin
        if (ram_cs && ram_w_en) mem[ram_addr] <= ram_din;
        if (ram_cs && ram_r_en) ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    // per-cycle monitor: strobe exclusivity and quiet port while idle
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (ram_w_en && ram_r_en) begin
                n_fail++;
                $display("FAIL mon_wr_rd_overlap t=%0t: w_en=%0b r_en=%0b required not both", $time, ram_w_en, ram_r_en);
            end
            if (req_ready) begin
                n_cmp++;
                if (ram_cs || ram_w_en || ram_r_en || ram_o_en) begin
                    n_fail++;
                    $display("FAIL mon_idle_strobe t=%0t: cs/we/re/oe=%0b%0b%0b%0b required 0000", $time, ram_cs, ram_w_en, ram_r_en, ram_o_en);
                end
            end
            if (ram_cs && ram_w_en) wr_cnt++;
            if (done) done_cnt++;
        end
    end

    typedef struct {
        logic          rv, rw;
        logic [AW-1:0] ra, rl;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr, wr, cs, we, re, oe;
        logic [AW-1:0] addr;
        logic          rdv;
        logic [DW-1:0] rdd;
        logic          dn;
    } vec_t;

    function automatic vec_t mkv(logic rv, logic rw, logic [AW-1:0] ra, logic [AW-1:0] rl,
                                 logic wv, logic [DW-1:0] wd,
                                 logic rr, logic wr, logic cs, logic we, logic re, logic oe,
                                 logic [AW-1:0] addr, logic rdv, logic [DW-1:0] rdd, logic dn);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ra = ra; v.rl = rl; v.wv = wv; v.wd = wd;
        v.rr = rr; v.wr = wr; v.cs = cs; v.we = we; v.re = re; v.oe = oe;
        v.addr = addr; v.rdv = rdv; v.rdd = rdd; v.dn = dn;
        return v;
    endfunction

    vec_t vecs [24];

    initial begin
        int wr_base;
        for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k);
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 0;

        //              rv rw ra  rl wv wd     rr wr cs we re oe addr rdv rdd    dn
        // burst write addr 3, 3 beats
        vecs[0]  = mkv(1, 1, 3,  2, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0,  0, 8'h00, 0);
        vecs[1]  = mkv(0, 0, 0,  0, 1, 8'hA1, 0, 1, 1, 1, 0, 0, 3,  0, 8'h00, 0);
        vecs[2]  = mkv(0, 0, 0,  0, 1, 8'hA2, 0, 1, 1, 1, 0, 0, 4,  0, 8'h00, 0);
        vecs[3]  = mkv(0, 0, 0,  0, 1, 8'hA3, 0, 1, 1, 1, 0, 0, 5,  0, 8'h00, 0);
        vecs[4]  = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 5,  0, 8'h00, 1);
        vecs[5]  = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 5,  0, 8'h00, 0);
        // gapped write addr 10, 2 beats, wr_valid 1,0,1
        vecs[6]  = mkv(1, 1, 10, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 5,  0, 8'h00, 0);
        vecs[7]  = mkv(0, 0, 0,  0, 1, 8'h5A, 0, 1, 1, 1, 0, 0, 10, 0, 8'h00, 0);
        vecs[8]  = mkv(0, 0, 0,  0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 11, 0, 8'h00, 0);
        vecs[9]  = mkv(0, 0, 0,  0, 1, 8'h5B, 0, 1, 1, 1, 0, 0, 11, 0, 8'h00, 0);
        vecs[10] = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 11, 0, 8'h00, 1);
        // wrap read addr 30, 4 beats; busy command at 13/14 must be ignored
        vecs[11] = mkv(1, 0, 30, 3, 0, 8'h00, 1, 0, 0, 0, 0, 0, 11, 0, 8'h00, 0);
        vecs[12] = mkv(0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 30, 0, 8'h00, 0);
        vecs[13] = mkv(1, 1, 7,  0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 31, 0, 8'h00, 0);
        vecs[14] = mkv(1, 1, 7,  0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0,  1, 8'h1E, 0);
        vecs[15] = mkv(0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1,  1, 8'h1F, 0);
        vecs[16] = mkv(0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1,  1, 8'h00, 0);
        vecs[17] = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1,  1, 8'h01, 1);
        vecs[18] = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1,  0, 8'h00, 0);
        // single-beat read of addr 4 (written A2 above)
        vecs[19] = mkv(1, 0, 4,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1,  0, 8'h00, 0);
        vecs[20] = mkv(0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 4,  0, 8'h00, 0);
        vecs[21] = mkv(0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 4,  0, 8'h00, 0);
        vecs[22] = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 4,  1, 8'hA2, 1);
        vecs[23] = mkv(0, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 4,  0, 8'h00, 0);

        // reset state
        @(negedge clk);
        chk("rst_strobes", 0, {28'd0, ram_cs, ram_w_en, ram_r_en, ram_o_en}, 32'd0);
        chk("rst_rd_valid_done", 0, {30'd0, rd_valid, done}, 32'd0);
        chk("rst_rd_data", 0, 32'(rd_data), 32'd0);
        chk("rst_ram_addr", 0, 32'(ram_addr), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            req_valid = vecs[i].rv; req_write = vecs[i].rw;
            req_addr  = vecs[i].ra; req_len   = vecs[i].rl;
            wr_valid  = vecs[i].wv; wr_data   = vecs[i].wd;
            @(negedge clk);
            chk("ctl rr,wr,cs,we,re,oe,rdv,done", i,
                {24'd0, req_ready, wr_ready, ram_cs, ram_w_en, ram_r_en, ram_o_en, rd_valid, done},
                {24'd0, vecs[i].rr, vecs[i].wr, vecs[i].cs, vecs[i].we, vecs[i].re, vecs[i].oe, vecs[i].rdv, vecs[i].dn});
            chk("ram_addr", i, 32'(ram_addr), 32'(vecs[i].addr));
            if (vecs[i].we) chk("ram_din", i, 32'(ram_din), 32'(vecs[i].wd));
            if (vecs[i].rdv) chk("rd_data", i, 32'(rd_data), 32'(vecs[i].rdd));
        end

        chk("write_count", 0, 32'(wr_cnt), 32'd5);
        chk("mem3", 0, 32'(mem[3]), 32'h A1);
        chk("mem4", 0, 32'(mem[4]), 32'h A2);
        chk("mem5", 0, 32'(mem[5]), 32'h A3);
        chk("mem10", 0, 32'(mem[10]), 32'h 5A);
        chk("mem11", 0, 32'(mem[11]), 32'h 5B);
        chk("mem12_untouched", 0, 32'(mem[12]), 32'h 0C);

        // reset asserted on the 2nd beat of a 4-beat write
        wr_base  = wr_cnt;
        done_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = 1; req_addr = 20; req_len = 3; wr_valid = 0;
        @(posedge clk); #1;
        req_valid = 0; wr_valid = 1; wr_data = 8'hC1;
        @(negedge clk);
        chk("rstseq_beat1_we", 0, {31'd0, ram_w_en}, 32'd1);
        chk("rstseq_beat1_addr", 0, 32'(ram_addr), 32'd20);
        @(posedge clk); #1;
        wr_data = 8'hC2; rst = 1'b1;
        @(negedge clk);
        chk("rstseq_in_rst_strobes", 0, {28'd0, ram_cs, ram_w_en, ram_r_en, ram_o_en}, 32'd0);
        chk("rstseq_in_rst_done", 0, {30'd0, rd_valid, done}, 32'd0);
        @(posedge clk); #1;
        wr_data = 8'hC3; rst = 1'b0;
        @(negedge clk);
        chk("rstseq_req_ready", 0, {30'd0, req_ready, wr_ready}, 32'b10);
        chk("rstseq_cs_after", 0, {31'd0, ram_cs}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            wr_data = 8'hC4;
        end
        wr_valid = 0;
        @(negedge clk);
        chk("rstseq_no_done", 0, 32'(done_cnt), 32'd0);
        chk("rstseq_write_count", 0, 32'(wr_cnt - wr_base), 32'd1);
        chk("rstseq_mem20", 0, 32'(mem[20]), 32'h C1);
        chk("rstseq_mem21", 0, 32'(mem[21]), 32'h 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
